if_fetch: RTL

//  Instruction-fetch stage directly upstream of the instruction decoder. Owns the PC.

---
 rtl/if_fetch.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, issues credit-limited sequential fetches and buffers responses for decode.
// Response-to-inst_valid latency is one cycle; imem and decode both use valid/ready, and decode stalls hold the head.

module if_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // The credit rule upstream must make this unreachable.
  always @(posedge clk) begin
    if (rstn && do_push) assert (!full);
  end
endmodule

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redir_valid,
  input  logic [1:0]  redir_npcop,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_rs,
  output logic        err_misalign
);
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nxt;

  logic [31:0]   pc;
  logic [31:0]   target;
  logic [31:0]   seq_pc;
  logic [31:0]   br_off;
  logic [31:0]   pc_tag;
  logic [63:0]   head;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic          redir_take;
  logic          req_fire;
  logic          push;
  logic          pop;

  assign redir_take   = redir_valid && (redir_npcop != NPC_PLUS4);
  assign err_misalign = redir_valid && (redir_npcop == NPC_JR) && (redir_rs[1:0] != 2'b00);
  assign seq_pc       = redir_pc + 32'd4;
  assign br_off       = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};

  always_comb begin
    target = {redir_rs[31:2], 2'b00};
    case (redir_npcop)
      NPC_BRANCH: target = seq_pc + br_off;
      NPC_JUMP:   target = {seq_pc[31:28], redir_imm, 2'b00};
      default:    target = {redir_rs[31:2], 2'b00};
    endcase
  end

  // Buffered words plus every request still in flight (stale ones included) share DEPTH credits.
  assign inflight = {1'b0, count} + {1'b0, outst};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        imem_req_valid = (inflight < LIMIT) && !redir_take;
        imem_req_addr  = pc;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_rsp_valid && (drop == '0) && !redir_take;
  assign pop      = inst_valid && inst_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else begin
      if (redir_take)    pc <= target;
      else if (req_fire) pc <= pc + 32'd4;
      // After a redirect every request still in flight is stale, whether or not it was already marked.
      if (redir_take)                         drop <= outst - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)  drop <= drop - CW'(1);
    end
  end

  // Address tags of outstanding requests; its occupancy is the outstanding count.
  if_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .rstn  (rstn),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (pc),
    .pop   (imem_rsp_valid),
    .head  (pc_tag),
    .count (outst)
  );

  if_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redir_take),
    .push  (push),
    .wdata ({imem_rsp_data, pc_tag}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head[63:32] : '0;
  assign inst_pc    = inst_valid ? head[31:0]  : '0;
endmodule
